// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// FSM states, opcode/funct constants, ALUOp and ALU operation codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: (aluop, funct) -> aluoperations.
// Unknown funct codes fall back to ADD.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] aluoperations
);

   always_comb begin
      aluoperations = ALU_ADD;
      unique case (aluop)
         ALUOP_ADD: aluoperations = ALU_ADD;
         ALUOP_SUB: aluoperations = ALU_SUB;
         ALUOP_FUNCT: begin
            unique case (1'b1)
               (funct == FN_SUB): aluoperations = ALU_SUB;
               (funct == FN_AND): aluoperations = ALU_AND;
               (funct == FN_OR):  aluoperations = ALU_OR;
               (funct == FN_SLT): aluoperations = ALU_SLT;
               default:           aluoperations = ALU_ADD;
            endcase
         end
         default: aluoperations = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle MIPS datapath.
// Ports: opcode/funct from IR, isZero, memReady in; mux selects,
// write enables, ALUoperations, instrDone, illegalInstr out.
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       isZero,
   input  logic       memReady,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUoperations,
   output logic       instrDone,
   output logic       illegalInstr
);

   state_t state;
   aluop_t aluop;
   logic   rdy;
   logic   pcwrite;
   logic   branch;
   logic   legal;

   assign rdy = USE_MEM_READY ? memReady : 1'b1;

   assign legal = (opcode == OP_LW)    ||
                  (opcode == OP_SW)    ||
                  (opcode == OP_RTYPE) ||
                  (opcode == OP_BEQ)   ||
                  (opcode == OP_ADDI)  ||
                  (opcode == OP_J);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         unique case (state)
            S_FETCH:
               if (rdy) state <= S_DECODE;
            S_DECODE: begin
               unique case (1'b1)
                  (opcode == OP_LW),
                  (opcode == OP_SW):    state <= S_MEMADR;
                  (opcode == OP_RTYPE): state <= S_RTYPEEX;
                  (opcode == OP_BEQ):   state <= S_BEQEX;
                  (opcode == OP_ADDI):  state <= S_ADDIEX;
                  (opcode == OP_J):     state <= S_JEX;
                  default:              state <= S_FETCH;
               endcase
            end
            S_MEMADR:
               state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:
               if (rdy) state <= S_MEMWB;
            S_MEMWR:
               if (rdy) state <= S_FETCH;
            S_RTYPEEX: state <= S_RTYPEWB;
            S_ADDIEX:  state <= S_ADDIWB;
            default:   state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      IorD         = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      PCSrc        = 2'b00;
      aluop        = ALUOP_ADD;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      instrDone    = 1'b0;
      illegalInstr = 1'b0;
      unique case (state)
         S_FETCH: begin
            ALUSrcB = 2'b01;
            IRWrite = rdy;
            pcwrite = rdy;
         end
         S_DECODE: begin
            ALUSrcB      = 2'b11;
            illegalInstr = ~legal;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWB: begin
            MemtoReg  = 1'b1;
            RegWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_MEMWR: begin
            IorD      = 1'b1;
            MemWrite  = 1'b1;
            instrDone = rdy;
         end
         S_RTYPEEX: begin
            ALUSrcA = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            RegDst    = 1'b1;
            RegWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_BEQEX: begin
            ALUSrcA   = 1'b1;
            aluop     = ALUOP_SUB;
            PCSrc     = 2'b01;
            branch    = 1'b1;
            instrDone = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: begin
            RegWrite  = 1'b1;
            instrDone = 1'b1;
         end
         S_JEX: begin
            PCSrc     = 2'b10;
            pcwrite   = 1'b1;
            instrDone = 1'b1;
         end
         default: ;
      endcase
      PCEn = pcwrite | (branch & isZero);
      // Reset overrides every enable so no write escapes an aborted state.
      if (reset) begin
         PCEn         = 1'b0;
         IRWrite      = 1'b0;
         MemWrite     = 1'b0;
         RegWrite     = 1'b0;
         instrDone    = 1'b0;
         illegalInstr = 1'b0;
      end
   end

   alu_decoder u_alu_decoder (
      .aluop         (aluop),
      .funct         (funct),
      .aluoperations (ALUoperations)
   );

endmodule
